// File: rtl/variable_table_controller_pkg.sv
// Shared state encoding and address helpers for the variable table controller.
package vt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLIP_RD,
    FLIP_WR
  } state_e;

  // Upper bound on CLUSTER_SIZE * VARIABLE_ADDRESS_WIDTH the helper can build.
  localparam int unsigned REP_MAX_W = 1024;

  // Copies one variable address into every lane slot so all lane copies see the same access.
  function automatic logic [REP_MAX_W-1:0] replicate_addr(
    input logic [31:0] addr,
    input int unsigned aw,
    input int unsigned cs
  );
    logic [REP_MAX_W-1:0] rep;
    rep = '0;
    for (int unsigned i = 0; i < cs; i++) begin
      for (int unsigned j = 0; j < aw; j++) begin
        if ((i * aw + j) < REP_MAX_W && j < 32) begin
          rep[i*aw+j] = addr[j];
        end
      end
    end
    return rep;
  endfunction

endpackage

// File: rtl/variable_table_controller_if.sv
// Port bundle between the controller and one Variable_Table_Cluster instance.
interface variable_table_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned CS = 40
);
  logic          axi_en;
  logic          axi_wr_en;
  logic [AW-1:0] axi_addr;
  logic          axi_data;

  logic             en;
  logic             wr_en;
  logic [CS*AW-1:0] addr;
  logic             wdata;
  logic [CS-1:0]    rdata;

  modport master (
    output axi_en, axi_wr_en, axi_addr, axi_data,
    output en, wr_en, addr, wdata,
    input  rdata
  );

  modport slave (
    input  axi_en, axi_wr_en, axi_addr, axi_data,
    input  en, wr_en, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/variable_table_controller_sat_counter.sv
// Saturating event counter with a clear that dominates the increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/variable_table_controller.sv
// Arbitrates config writes, flip read-modify-writes and multi-lane reads onto one variable table.
module variable_table_controller
  import vt_ctrl_pkg::*;
#(
  parameter int unsigned VARIABLE_ADDRESS_WIDTH = 11,
  parameter int unsigned CLUSTER_SIZE           = 40,
  parameter int unsigned CNT_WIDTH              = 32
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,

  input  logic                                          cfg_valid_i,
  output logic                                          cfg_ready_o,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0]             cfg_addr_i,
  input  logic                                          cfg_data_i,

  input  logic                                          flip_valid_i,
  output logic                                          flip_ready_o,
  input  logic [VARIABLE_ADDRESS_WIDTH-1:0]             flip_addr_i,
  output logic                                          flip_done_o,
  output logic                                          flip_old_o,

  input  logic                                          rd_valid_i,
  output logic                                          rd_ready_o,
  input  logic [CLUSTER_SIZE*VARIABLE_ADDRESS_WIDTH-1:0] rd_addr_mi,
  output logic                                          rd_valid_o,
  output logic [CLUSTER_SIZE-1:0]                       rd_data_mo,

  variable_table_if.master                              tbl,

  output logic                                          busy_o,
  output logic                                          coh_err_o,
  output logic [CNT_WIDTH-1:0]                          flip_count_o,
  input  logic                                          cnt_clr_i
);

  localparam int unsigned AW = VARIABLE_ADDRESS_WIDTH;
  localparam int unsigned CS = CLUSTER_SIZE;

  state_e            state;
  state_e            state_n;
  logic [AW-1:0]     flip_addr_q;
  logic [CS*AW-1:0]  flip_addr_rep;
  logic              flip_accept;
  logic              rd_accept;
  logic              rd_valid_q;
  logic              flip_done_q;
  logic              flip_old_q;
  logic              coh_err_q;
  logic              lane_mismatch;

  assign flip_addr_rep = (CS*AW)'(replicate_addr(32'(flip_addr_q), AW, CS));
  assign lane_mismatch = (tbl.rdata != '0) && (tbl.rdata != '1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Everything that can touch the table is forced quiet while rst_ni is low.
  always_comb begin
    state_n       = state;
    cfg_ready_o   = 1'b0;
    flip_ready_o  = 1'b0;
    rd_ready_o    = 1'b0;
    flip_accept   = 1'b0;
    rd_accept     = 1'b0;
    tbl.axi_en    = 1'b0;
    tbl.axi_wr_en = 1'b0;
    tbl.axi_addr  = '0;
    tbl.axi_data  = 1'b0;
    tbl.en        = 1'b0;
    tbl.wr_en     = 1'b0;
    tbl.addr      = '0;
    tbl.wdata     = 1'b0;

    if (rst_ni) begin
      case (state)
        IDLE: begin
          cfg_ready_o  = 1'b1;
          flip_ready_o = !cfg_valid_i;
          rd_ready_o   = !cfg_valid_i && !flip_valid_i;
          if (cfg_valid_i) begin
            tbl.axi_en    = 1'b1;
            tbl.axi_wr_en = 1'b1;
            tbl.axi_addr  = cfg_addr_i;
            tbl.axi_data  = cfg_data_i;
          end else if (flip_valid_i) begin
            flip_accept = 1'b1;
            state_n     = FLIP_RD;
          end else if (rd_valid_i) begin
            rd_accept = 1'b1;
            tbl.en    = 1'b1;
            tbl.addr  = rd_addr_mi;
          end
        end
        FLIP_RD: begin
          tbl.en   = 1'b1;
          tbl.addr = flip_addr_rep;
          state_n  = FLIP_WR;
        end
        FLIP_WR: begin
          tbl.en    = 1'b1;
          tbl.wr_en = 1'b1;
          tbl.addr  = flip_addr_rep;
          tbl.wdata = ~tbl.rdata[0];
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    busy_o = rst_ni && (state != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      flip_addr_q <= '0;
      rd_valid_q  <= 1'b0;
      flip_done_q <= 1'b0;
      flip_old_q  <= 1'b0;
      coh_err_q   <= 1'b0;
    end else begin
      rd_valid_q  <= rd_accept;
      flip_done_q <= (state == FLIP_WR);
      if (flip_accept) begin
        flip_addr_q <= flip_addr_i;
      end
      if (state == FLIP_WR) begin
        flip_old_q <= tbl.rdata[0];
        if (lane_mismatch) begin
          coh_err_q <= 1'b1;
        end
      end
    end
  end

  assign rd_valid_o  = rd_valid_q && rst_ni;
  assign rd_data_mo  = rd_valid_o ? tbl.rdata : '0;
  assign flip_done_o = flip_done_q && rst_ni;
  assign flip_old_o  = flip_old_q;
  assign coh_err_o   = coh_err_q;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flip_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (flip_done_o),
    .clr_i  (cnt_clr_i),
    .cnt_o  (flip_count_o)
  );

endmodule

// File: tb/tb_variable_table_controller.sv
// Directed bench for variable_table_controller against a registered-read table model.
module tb_variable_table_controller;

  localparam int unsigned AW = 11;
  localparam int unsigned CS = 40;
  localparam int unsigned CW = 4;
  localparam logic [63:0] ALL1 = 64'h0000_00FF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             cfg_valid, cfg_ready, cfg_data;
  logic [AW-1:0]    cfg_addr;
  logic             flip_valid, flip_ready, flip_done, flip_old;
  logic [AW-1:0]    flip_addr;
  logic             rd_valid, rd_ready, rd_valid_out;
  logic [CS*AW-1:0] rd_addr;
  logic [CS-1:0]    rd_data;
  logic             busy, coh_err, cnt_clr;
  logic [CW-1:0]    flip_count;

  variable_table_if #(.AW(AW), .CS(CS)) tbl ();

  variable_table_controller #(
    .VARIABLE_ADDRESS_WIDTH (AW),
    .CLUSTER_SIZE           (CS),
    .CNT_WIDTH              (CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_data),
    .flip_valid_i (flip_valid),
    .flip_ready_o (flip_ready),
    .flip_addr_i  (flip_addr),
    .flip_done_o  (flip_done),
    .flip_old_o   (flip_old),
    .rd_valid_i   (rd_valid),
    .rd_ready_o   (rd_ready),
    .rd_addr_mi   (rd_addr),
    .rd_valid_o   (rd_valid_out),
    .rd_data_mo   (rd_data),
    .tbl          (tbl),
    .busy_o       (busy),
    .coh_err_o    (coh_err),
    .flip_count_o (flip_count),
    .cnt_clr_i    (cnt_clr)
  );

  // Table model: per-lane copies, AXI writes hit every lane, reads registered.
  logic [CS-1:0] mem [2**AW] = '{default: '0};
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [CS-1:0] bd_val = '0;

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_val;
    if (tbl.axi_en && tbl.axi_wr_en) mem[tbl.axi_addr] <= {CS{tbl.axi_data}};
    if (tbl.en) begin
      for (int l = 0; l < CS; l++) begin
        if (tbl.wr_en) mem[tbl.addr[l*AW +: AW]][l] <= tbl.wdata;
        else           tbl.rdata[l] <= mem[tbl.addr[l*AW +: AW]][l];
      end
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CS*AW-1:0] rep(input logic [AW-1:0] a);
    logic [CS*AW-1:0] r;
    for (int l = 0; l < CS; l++) r[l*AW +: AW] = a;
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [CS-1:0] v);
    bd_en = 1'b1; bd_addr = a; bd_val = v;
    tick();
    bd_en = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [CS*AW-1:0] a, input logic [63:0] exp);
    rd_valid = 1'b1; rd_addr = a;
    #2 check({tag, "_rd_ready"}, 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    #2 check({tag, "_rd_valid"}, 64'(rd_valid_out), 64'd1);
    check({tag, "_rd_data"}, 64'(rd_data), exp);
  endtask

  // Returns one cycle after the done pulse so the counter update is visible.
  task automatic do_flip(input logic [AW-1:0] a, input logic exp_old, input logic clr_at_done);
    logic exp_w;
    exp_w = ~exp_old;
    flip_valid = 1'b1; flip_addr = a;
    #2 check("flip_ready", 64'(flip_ready), 64'd1);
    tick();
    flip_valid = 1'b0;
    #2 check("flip_rd_busy", 64'(busy), 64'd1);
    check("flip_rd_addr", 64'(tbl.en && !tbl.wr_en && (tbl.addr == rep(a))), 64'd1);
    check("flip_rd_done", 64'(flip_done), 64'd0);
    tick();
    #2 check("flip_wr_en", 64'(tbl.en && tbl.wr_en), 64'd1);
    check("flip_wdata", 64'(tbl.wdata), 64'(exp_w));
    check("flip_wr_done", 64'(flip_done), 64'd0);
    tick();
    cnt_clr = clr_at_done;
    #2 check("flip_done", 64'(flip_done), 64'd1);
    check("flip_old", 64'(flip_old), 64'(exp_old));
    check("flip_idle", 64'(busy), 64'd0);
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 11'h1FF; cfg_data = 1'b1;
    flip_valid = 1'b0; flip_addr = '0;
    rd_valid = 1'b0; rd_addr = '0;
    cnt_clr = 1'b0;

    // Reset: everything quiet, even with a config request pending.
    tick();
    #2 check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_axi_en", 64'(tbl.axi_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(flip_count), 64'd0);
    check("rst_coh", 64'(coh_err), 64'd0);
    check("rst_old", 64'(flip_old), 64'd0);
    check("rst_done", 64'(flip_done), 64'd0);
    check("rst_rd_valid", 64'(rd_valid_out), 64'd0);
    tick();
    check("rst_no_axi_write", 64'(mem[11'h1FF]), 64'd0);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Back-to-back config writes.
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_addr = AW'(5 + i); cfg_data = 1'b1;
      #2 check("cfg_ready", 64'(cfg_ready), 64'd1);
      check("cfg_axi_wr", 64'(tbl.axi_en && tbl.axi_wr_en), 64'd1);
      check("cfg_axi_addr", 64'(tbl.axi_addr), 64'(5 + i));
      check("cfg_busy", 64'(busy), 64'd0);
      tick();
    end
    cfg_valid = 1'b0;
    do_read("cfg_rb", rep(11'h006), ALL1);

    // Flip a preloaded zero.
    preload(11'h00A, '0);
    do_flip(11'h00A, 1'b0, 1'b0);
    #2 check("flip1_count", 64'(flip_count), 64'd1);
    check("flip1_done_gone", 64'(flip_done), 64'd0);
    do_read("flip1_rb", rep(11'h00A), ALL1);

    // All three requesters at once.
    tick();
    cfg_valid = 1'b1; cfg_addr = 11'h020; cfg_data = 1'b1;
    flip_valid = 1'b1; flip_addr = 11'h00B;
    rd_valid = 1'b1; rd_addr = rep(11'h020);
    #2 check("arb_cfg_ready", 64'(cfg_ready), 64'd1);
    check("arb_flip_ready0", 64'(flip_ready), 64'd0);
    check("arb_rd_ready0", 64'(rd_ready), 64'd0);
    check("arb_axi_only", 64'({tbl.axi_en, tbl.en}), 64'd2);
    tick();
    cfg_valid = 1'b0;
    #2 check("arb_flip_ready", 64'(flip_ready), 64'd1);
    check("arb_rd_ready1", 64'(rd_ready), 64'd0);
    tick();
    flip_valid = 1'b0;
    #2 check("arb_rd_wait_rd", 64'(rd_ready), 64'd0);
    tick();
    #2 check("arb_rd_wait_wr", 64'(rd_ready), 64'd0);
    tick();
    #2 check("arb_done", 64'(flip_done), 64'd1);
    check("arb_rd_ready", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    #2 check("arb_rd_valid", 64'(rd_valid_out), 64'd1);
    check("arb_rd_data", 64'(rd_data), ALL1);
    check("arb_count", 64'(flip_count), 64'd2);
    check("arb_coh_clean", 64'(coh_err), 64'd0);
    tick();

    // Pipelined reads, one result per cycle.
    preload(11'h003, '1);
    preload(11'h007, '0);
    rd_valid = 1'b1; rd_addr = rep(11'h003);
    tick();
    rd_addr = rep(11'h007);
    #2 check("pipe_v0", 64'(rd_valid_out), 64'd1);
    check("pipe_d0", 64'(rd_data), ALL1);
    tick();
    rd_valid = 1'b0;
    #2 check("pipe_v1", 64'(rd_valid_out), 64'd1);
    check("pipe_d1", 64'(rd_data), 64'd0);
    tick();
    #2 check("pipe_v2", 64'(rd_valid_out), 64'd0);

    // Distinct address per lane: lane l reads 0x100+l, odd lanes hold 1.
    for (int l = 0; l < CS; l++) preload(AW'(256 + l), (l % 2 == 1) ? '1 : '0);
    begin
      logic [CS*AW-1:0] la;
      for (int l = 0; l < CS; l++) la[l*AW +: AW] = AW'(256 + l);
      do_read("lanes", la, 64'h0000_00AA_AAAA_AAAA);
    end
    tick();

    // Lane mismatch during a flip sets the sticky coherence flag.
    preload(11'h030, 40'h00_0000_00F0);
    do_flip(11'h030, 1'b0, 1'b0);
    #2 check("coh_set", 64'(coh_err), 64'd1);
    do_flip(11'h00A, 1'b1, 1'b0);
    #2 check("coh_sticky", 64'(coh_err), 64'd1);
    check("flip4_count", 64'(flip_count), 64'd4);

    // Reset landing in FLIP_WR: no write, state cleared.
    flip_valid = 1'b1; flip_addr = 11'h040;
    tick();
    flip_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #2 check("rstwr_en", 64'({tbl.en, tbl.wr_en}), 64'd0);
    check("rstwr_busy", 64'(busy), 64'd0);
    tick();
    #2 check("rstwr_count", 64'(flip_count), 64'd0);
    check("rstwr_coh", 64'(coh_err), 64'd0);
    check("rstwr_old", 64'(flip_old), 64'd0);
    check("rstwr_mem", 64'(mem[11'h040]), 64'd0);
    rst_n = 1'b1;
    tick();
    #2 check("rstwr_no_done", 64'(flip_done), 64'd0);
    check("rstwr_idle", 64'(busy), 64'd0);

    // Counter saturation on the 4-bit build.
    for (int n = 1; n <= 16; n++) begin
      do_flip(11'h050, 1'((n - 1) % 2), 1'b0);
      #2 check("sat_count", 64'(flip_count), (n > 15) ? 64'd15 : 64'(n));
    end

    // Clear wins over the coincident increment.
    do_flip(11'h050, 1'b0, 1'b1);
    #2 check("clr_vs_inc", 64'(flip_count), 64'd0);
    do_flip(11'h050, 1'b1, 1'b0);
    #2 check("after_clr", 64'(flip_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/variable_table_controller.md
Name: variable_table_controller

Overview:
- Sequences and arbitrates all accesses to one Variable_Table_Cluster instance.
- Three requesters share the table:
  - the AXI configuration loader (initial assignment writes);
  - the flip engine (read-modify-write inversion of one variable);
  - the clause-evaluation front end (packed multi-lane reads).
- Keeps every lane copy coherent by driving replicated addresses on all writes, and counts completed flips.

Parameters:
- VARIABLE_ADDRESS_WIDTH, 11, variable index width (AW).
- CLUSTER_SIZE, 40, number of table lanes (CS).
- CNT_WIDTH, 32, flip counter width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- cfg_valid_i  in  1  AXI loader write request.
- cfg_ready_o  out  1  config write accepted this cycle.
- cfg_addr_i  in  AW  config variable address.
- cfg_data_i  in  1  config value.
- flip_valid_i  in  1  flip request.
- flip_ready_o  out  1  flip accepted this cycle.
- flip_addr_i  in  AW  variable to invert.
- flip_done_o  out  1  one-cycle pulse when a flip completes.
- flip_old_o  out  1  pre-flip value of the last completed flip.
- rd_valid_i  in  1  evaluation read request.
- rd_ready_o  out  1  read accepted this cycle.
- rd_addr_mi  in  CS*AW  packed per-lane read addresses.
- rd_valid_o  out  1  read data valid.
- rd_data_mo  out  CS  per-lane read data.
- tbl_axi_en_o, tbl_axi_wr_en_o  out  1 each  table AXI port enables.
- tbl_axi_addr_o  out  AW  table AXI port address.
- tbl_axi_data_o  out  1  table AXI port data.
- tbl_en_o, tbl_wr_en_o  out  1 each  table runtime port enables.
- tbl_addr_mo  out  CS*AW  table runtime port addresses.
- tbl_data_o  out  1  table runtime write data.
- tbl_data_mi  in  CS  table read data (registered in table, 1-cycle latency).
- busy_o  out  1  state != IDLE.
- coh_err_o  out  1  sticky lane-mismatch flag.
- flip_count_o  out  CNT_WIDTH  completed flips, saturating.
- cnt_clr_i  in  1  synchronous clear of flip_count_o.

Behaviour:
- Reset: state=IDLE. All outputs 0 (flip_old_o, coh_err_o and flip_count_o included). Any in-flight flip is dropped.
- Table enables are combinationally gated by rst_ni, so no table write occurs in any cycle where rst_ni=0, including the FLIP_WR cycle.
- States:
  - IDLE: arbitration, priority cfg > flip > rd. Only the winner is acknowledged.
    - cfg wins: cfg_ready_o=1, and in the same cycle tbl_axi_en_o=tbl_axi_wr_en_o=1 with cfg_addr_i/cfg_data_i. Stay in IDLE, so back-to-back config writes run one per cycle.
    - flip wins (no cfg_valid_i): flip_ready_o=1, latch flip_addr_i, go to FLIP_RD.
    - rd wins (neither of the above): rd_ready_o=1, tbl_en_o=1, tbl_wr_en_o=0, tbl_addr_mo=rd_addr_mi. rd_valid_o=1 in the next cycle with rd_data_mo=tbl_data_mi. Back-to-back reads give one result per cycle.
  - FLIP_RD: tbl_en_o=1, tbl_wr_en_o=0, tbl_addr_mo = latched address replicated CS times. Go to FLIP_WR.
  - FLIP_WR:
    - tbl_data_mi is valid. Drive tbl_en_o=tbl_wr_en_o=1, replicated address, tbl_data_o=~tbl_data_mi[0].
    - Register flip_old_o=tbl_data_mi[0].
    - If tbl_data_mi is not all-0 and not all-1, set coh_err_o (cleared only by reset).
    - Go to IDLE.
- flip_done_o pulses in the first IDLE cycle after FLIP_WR, so accept-to-done latency is 3 cycles. A new request may be accepted in that same cycle.
- rd_valid_o for a read accepted in the cycle before a flip/cfg acceptance is still delivered; the pipeline stage is independent of state.
- All ready outputs are 0 outside IDLE.
- flip_count_o:
  - +1 on the flip_done_o pulse; saturates at all-ones.
  - cnt_clr_i has priority over increment in the same cycle.
- Ready signals never depend combinationally on the valid of the same requester; they depend only on higher-priority valids.

Decomposition:
- Package vt_ctrl_pkg holds the state enum (IDLE, FLIP_RD, FLIP_WR) and the replicate-address helper function.
- The saturating counter is a natural sub-module: sat_counter (WIDTH, inc_i, clr_i, cnt_o).
- Everything else stays inline.

Test Plan:
- cfg_valid_i for 3 consecutive cycles, addr 0x005/0x006/0x007, data 1 → cfg_ready_o=1 each cycle; tbl_axi_wr_en_o=1 for 3 cycles; busy_o stays 0.
- Table preloaded 0x00A=0, flip_valid_i addr 0x00A:
  - flip_done_o exactly 3 cycles after acceptance; flip_old_o=0.
  - A subsequent read of 0x00A on all lanes returns all 1s; flip_count_o=1.
- cfg_valid_i, flip_valid_i and rd_valid_i all asserted together → only cfg_ready_o=1. Next cycle only flip_ready_o=1. rd_ready_o=1 only after flip_done_o.
- Pipelined reads to 0x003 then 0x007 on all lanes, with values 1 and 0 → rd_valid_o on 2 consecutive cycles, rd_data_mo = all 1s then all 0s.
- Table model returns mixed lane data during FLIP_WR → coh_err_o=1 and stays 1 until rst_ni=0.
- Robustness:
  - rst_ni=0 during FLIP_WR → no table write; outputs 0; the variable keeps its old value.
  - flip_count_o preset near max via 2^CNT_WIDTH flips (CNT_WIDTH=4 build) saturates at 15.
  - cnt_clr_i coinciding with flip_done_o gives 0.
